matmul_tile_sequencer: RTL and testbench
========================================

Name: matmul_tile_sequencer

Overview:
- Parametrised successor to the single-shot matmul top-level start/done controller.
- Tiles an (M·T)x(K·T) by (K·T)x(N·T) product into a sequence of TxT systolic-core invocations, iterating m, n, k.
- Generates per-tile A/B/C base addresses, accumulator-clear pulses and the core start/done handshake.
- Sits between the register block (start_reg/clear_done_reg) and the matmul_8x8_systolic-class core.

Parameters:
AWIDTH, 11, BRAM word-address width
STEP_WIDTH, 8, width of each per-tile address step input
TCW, 4, width of tile-count inputs (max 2^TCW-1 tiles per dimension)

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
start_reg  input  1  start request, level, sampled in IDLE only
clear_done_reg  input  1  acknowledge done, sampled in DONE only
num_tiles_m / num_tiles_n / num_tiles_k  input  TCW each  tile counts per dimension
base_a / base_b / base_c  input  AWIDTH each  matrix base addresses
step_a_m / step_a_k / step_b_k / step_b_n / step_c_m / step_c_n  input  STEP_WIDTH each  address increment per tile index
core_done  input  1  core completion, level
core_start  output  1  core start, held until core_done seen
core_pe_resetn  output  1  active-low accumulator clear to core
core_last_k  output  1  high while current tile is last k (core writes C only then)
core_addr_a / core_addr_b / core_addr_c  output  AWIDTH each  tile base addresses
busy  output  1  high in every state except IDLE and DONE
done  output  1  high in DONE
tiles_issued  output  3*TCW  count of core invocations completed in this job

Behaviour:
- Reset (resetn=0 at posedge): state IDLE; core_start=0, core_pe_resetn=1, core_last_k=0, addresses=0, busy=0, done=0, tiles_issued=0; m/n/k indices=0. Applies mid-job; core_start drops in the next cycle.
- Address arithmetic, unsigned, modulo 2^AWIDTH (wrap, no flag):
  - core_addr_a = base_a + m·step_a_m + k·step_a_k
  - core_addr_b = base_b + k·step_b_k + n·step_b_n
  - core_addr_c = base_c + m·step_c_m + n·step_c_n
  - Maintained incrementally with running accumulators, no multipliers.
- Loop order: k innermost, then n, then m.
- States:
  - IDLE: if start_reg=1, latch all config inputs, clear indices and tiles_issued.
    - If any num_tiles_*=0, go to DONE (no core activity, tiles_issued=0).
    - Otherwise go to LOAD.
  - LOAD (1 cycle): present addresses for (m,n,k); core_last_k=(k==num_k-1); core_pe_resetn=0 iff k==0; go to START.
  - START: core_pe_resetn=1, core_start=1; go to WAIT.
  - WAIT: hold core_start=1 and addresses stable. On core_done=1: core_start=0, tiles_issued+1, go to GAP.
  - GAP: wait for core_done=0, then:
    - last k/n/m → DONE.
    - Otherwise advance k; on k wrap advance n; on n wrap advance m; go to LOAD.
  - DONE: done=1, core_last_k=0. On clear_done_reg=1 go to IDLE (done=0 next cycle).
- Timing: start_reg high in IDLE at cycle t → LOAD at t+1 (pe_resetn low during t+1) → core_start=1 from t+2.
- Per-tile overhead: 3 cycles (GAP min 1, LOAD, START) plus core latency.
- Ignored inputs:
  - start_reg outside IDLE.
  - clear_done_reg outside DONE.
  - Config input changes after latch.
  - core_done outside WAIT/GAP.
- Simultaneous start_reg and clear_done_reg in DONE: clear wins; start requires IDLE, so it is re-sampled the cycle after.
- core_done already high on entry to WAIT (stale): accepted as completion. The core must drop done before the next start, which GAP enforces.

Test Plan:
- Reset mid-WAIT: job 2x2x2 running, resetn=0 one cycle → next cycle core_start=0, busy=0, tiles_issued=0, state IDLE.
- Single tile: all counts=1, bases A=0x010/B=0x020/C=0x030, core_done after 5 cycles → exactly one core_start pulse train; core_pe_resetn low only in cycle t+1; core_last_k=1; done=1; tiles_issued=1.
- 2x2x2 job: steps a_m=16, a_k=8, b_k=16, b_n=8, c_m=16, c_n=8, bases 0 → 8 invocations with (a,b,c) sequence:
  - (0,0,0), (8,16,0), (0,8,8), (8,24,8), (16,0,16), (24,16,16), (16,8,24), (24,24,24)
  - core_pe_resetn low before the 1st, 3rd, 5th and 7th invocations; core_last_k on the even-numbered ones.
- Zero count: num_tiles_k=0, start_reg=1 → DONE in 1 cycle, core_start never asserted, tiles_issued=0.
- Wrap: base_a=0x7F8, step_a_k=16, num_k=2 → second tile core_addr_a=0x008.
- Handshake: core_done held high 4 cycles after completion → sequencer stays in GAP; next core_start occurs only after core_done falls; start_reg toggled while busy has no effect; clear_done_reg returns to IDLE with done=0.

Source files
------------

// File: rtl/matmul_tile_sequencer.sv
// Tiles a large matrix product into a sequence of TxT systolic-core invocations,
// walking m, n, k (k innermost) and handing the core per-tile base addresses.
module matmul_tile_sequencer #(
    parameter int AWIDTH     = 11,
    parameter int STEP_WIDTH = 8,
    parameter int TCW        = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start_reg,
    input  logic                  clear_done_reg,
    input  logic [TCW-1:0]        num_tiles_m,
    input  logic [TCW-1:0]        num_tiles_n,
    input  logic [TCW-1:0]        num_tiles_k,
    input  logic [AWIDTH-1:0]     base_a,
    input  logic [AWIDTH-1:0]     base_b,
    input  logic [AWIDTH-1:0]     base_c,
    input  logic [STEP_WIDTH-1:0] step_a_m,
    input  logic [STEP_WIDTH-1:0] step_a_k,
    input  logic [STEP_WIDTH-1:0] step_b_k,
    input  logic [STEP_WIDTH-1:0] step_b_n,
    input  logic [STEP_WIDTH-1:0] step_c_m,
    input  logic [STEP_WIDTH-1:0] step_c_n,
    input  logic                  core_done,
    output logic                  core_start,
    output logic                  core_pe_resetn,
    output logic                  core_last_k,
    output logic [AWIDTH-1:0]     core_addr_a,
    output logic [AWIDTH-1:0]     core_addr_b,
    output logic [AWIDTH-1:0]     core_addr_c,
    output logic                  busy,
    output logic                  done,
    output logic [3*TCW-1:0]      tiles_issued
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic [TCW-1:0]   ONE_T = 1;
    localparam logic [3*TCW-1:0] ONE_I = 1;

    state_t            state;
    logic [TCW-1:0]    num_m, num_n, num_k;
    logic [TCW-1:0]    m_idx, n_idx, k_idx;
    logic [AWIDTH-1:0] base_b_l;
    logic [AWIDTH-1:0] s_a_m, s_a_k, s_b_k, s_b_n, s_c_m, s_c_n;
    // Running partial sums: row_a = base_a + m*step_a_m, col_b = base_b + n*step_b_n,
    // row_c = base_c + m*step_c_m. The outputs carry the full per-tile sums.
    logic [AWIDTH-1:0] row_a, col_b, row_c;

    logic              k_last, n_last, m_last;
    logic [TCW-1:0]    k_nx;
    logic              last_k_nx;
    logic [AWIDTH-1:0] row_a_nx, col_b_nx, row_c_nx;

    always_comb begin
        k_last    = (k_idx + ONE_T) == num_k;
        n_last    = (n_idx + ONE_T) == num_n;
        m_last    = (m_idx + ONE_T) == num_m;
        k_nx      = k_last ? '0 : k_idx + ONE_T;
        last_k_nx = (k_nx + ONE_T) == num_k;
        row_a_nx  = row_a + s_a_m;
        col_b_nx  = col_b + s_b_n;
        row_c_nx  = row_c + s_c_m;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            core_start     <= 1'b0;
            core_pe_resetn <= 1'b1;
            core_last_k    <= 1'b0;
            core_addr_a    <= '0;
            core_addr_b    <= '0;
            core_addr_c    <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            tiles_issued   <= '0;
            m_idx          <= '0;
            n_idx          <= '0;
            k_idx          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_reg) begin
                        num_m        <= num_tiles_m;
                        num_n        <= num_tiles_n;
                        num_k        <= num_tiles_k;
                        base_b_l     <= base_b;
                        s_a_m        <= AWIDTH'(step_a_m);
                        s_a_k        <= AWIDTH'(step_a_k);
                        s_b_k        <= AWIDTH'(step_b_k);
                        s_b_n        <= AWIDTH'(step_b_n);
                        s_c_m        <= AWIDTH'(step_c_m);
                        s_c_n        <= AWIDTH'(step_c_n);
                        row_a        <= base_a;
                        col_b        <= base_b;
                        row_c        <= base_c;
                        core_addr_a  <= base_a;
                        core_addr_b  <= base_b;
                        core_addr_c  <= base_c;
                        m_idx        <= '0;
                        n_idx        <= '0;
                        k_idx        <= '0;
                        tiles_issued <= '0;
                        if (num_tiles_m == '0 || num_tiles_n == '0 || num_tiles_k == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state          <= ST_LOAD;
                            busy           <= 1'b1;
                            core_pe_resetn <= 1'b0;
                            core_last_k    <= (num_tiles_k == ONE_T);
                        end
                    end
                end
                ST_LOAD: begin
                    state          <= ST_START;
                    core_pe_resetn <= 1'b1;
                    core_start     <= 1'b1;
                end
                ST_START: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done level already present on entry counts as completion.
                    if (core_done) begin
                        state        <= ST_GAP;
                        core_start   <= 1'b0;
                        tiles_issued <= tiles_issued + ONE_I;
                    end
                end
                ST_GAP: begin
                    if (!core_done) begin
                        if (k_last && n_last && m_last) begin
                            state       <= ST_DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            core_last_k <= 1'b0;
                        end else begin
                            state          <= ST_LOAD;
                            k_idx          <= k_nx;
                            core_pe_resetn <= (k_nx != '0);
                            core_last_k    <= last_k_nx;
                            if (!k_last) begin
                                core_addr_a <= core_addr_a + s_a_k;
                                core_addr_b <= core_addr_b + s_b_k;
                            end else if (!n_last) begin
                                n_idx       <= n_idx + ONE_T;
                                col_b       <= col_b_nx;
                                core_addr_a <= row_a;
                                core_addr_b <= col_b_nx;
                                core_addr_c <= core_addr_c + s_c_n;
                            end else begin
                                n_idx       <= '0;
                                m_idx       <= m_idx + ONE_T;
                                row_a       <= row_a_nx;
                                col_b       <= base_b_l;
                                row_c       <= row_c_nx;
                                core_addr_a <= row_a_nx;
                                core_addr_b <= base_b_l;
                                core_addr_c <= row_c_nx;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (clear_done_reg) begin
                        state <= ST_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Bench for matmul_tile_sequencer: a behavioural core answers each start, a monitor
// compares every invocation against a queue filled from an index-loop reference model.
module tb_matmul_tile_sequencer;

    localparam int AW  = 11;
    localparam int SW  = 8;
    localparam int TCW = 4;

    logic clk = 1'b0;
    logic resetn, start_reg, clear_done_reg, core_done;
    logic [TCW-1:0] num_tiles_m, num_tiles_n, num_tiles_k;
    logic [AW-1:0]  base_a, base_b, base_c;
    logic [SW-1:0]  step_a_m, step_a_k, step_b_k, step_b_n, step_c_m, step_c_n;
    logic           core_start, core_pe_resetn, core_last_k, busy, done;
    logic [AW-1:0]  core_addr_a, core_addr_b, core_addr_c;
    logic [3*TCW-1:0] tiles_issued;

    matmul_tile_sequencer #(.AWIDTH(AW), .STEP_WIDTH(SW), .TCW(TCW)) dut (
        .clk(clk), .resetn(resetn), .start_reg(start_reg), .clear_done_reg(clear_done_reg),
        .num_tiles_m(num_tiles_m), .num_tiles_n(num_tiles_n), .num_tiles_k(num_tiles_k),
        .base_a(base_a), .base_b(base_b), .base_c(base_c),
        .step_a_m(step_a_m), .step_a_k(step_a_k), .step_b_k(step_b_k),
        .step_b_n(step_b_n), .step_c_m(step_c_m), .step_c_n(step_c_n),
        .core_done(core_done), .core_start(core_start), .core_pe_resetn(core_pe_resetn),
        .core_last_k(core_last_k), .core_addr_a(core_addr_a), .core_addr_b(core_addr_b),
        .core_addr_c(core_addr_c), .busy(busy), .done(done), .tiles_issued(tiles_issued)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nm, nn, nk;
        int ba, bb, bc;
        int sam, sak, sbk, sbn, scm, scn;
        int lat, hold, toggle;
        int exp_tiles;
    } job_t;

    typedef struct {
        int a, b, c;
        int last, clr;
    } inv_t;

    inv_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   inv_cnt = 0;
    int   core_lat = 3;
    int   core_hold = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural core: done rises core_lat cycles after start, stays for core_hold cycles.
    initial begin
        core_done = 1'b0;
        forever begin
            @(negedge clk);
            if (core_start === 1'b1 && !core_done) begin
                repeat (core_lat - 1) @(negedge clk);
                core_done = 1'b1;
                repeat (core_hold) @(negedge clk);
                core_done = 1'b0;
            end
        end
    end

    initial begin
        logic sp, pp;
        inv_t e;
        sp = 1'b0;
        pp = 1'b1;
        forever begin
            @(negedge clk);
            if (core_start === 1'b1 && sp !== 1'b1) begin
                inv_cnt++;
                check("start_with_done_low", core_done, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_invocation: got a=%0d b=%0d c=%0d required none",
                             core_addr_a, core_addr_b, core_addr_c);
                end else begin
                    e = exp_q.pop_front();
                    check("inv_addr_a", core_addr_a, e.a);
                    check("inv_addr_b", core_addr_b, e.b);
                    check("inv_addr_c", core_addr_c, e.c);
                    check("inv_last_k", core_last_k, e.last);
                    check("inv_clear_before", !pp, e.clr);
                end
            end
            sp = core_start;
            pp = core_pe_resetn;
        end
    end

    task automatic start_job(input job_t j);
        num_tiles_m = TCW'(j.nm);
        num_tiles_n = TCW'(j.nn);
        num_tiles_k = TCW'(j.nk);
        base_a = AW'(j.ba);
        base_b = AW'(j.bb);
        base_c = AW'(j.bc);
        step_a_m = SW'(j.sam);
        step_a_k = SW'(j.sak);
        step_b_k = SW'(j.sbk);
        step_b_n = SW'(j.sbn);
        step_c_m = SW'(j.scm);
        step_c_n = SW'(j.scn);
        core_lat = j.lat;
        core_hold = j.hold;
        for (int m = 0; m < j.nm; m++)
            for (int n = 0; n < j.nn; n++)
                for (int k = 0; k < j.nk; k++) begin
                    inv_t e;
                    e.a = (j.ba + m * j.sam + k * j.sak) % 2048;
                    e.b = (j.bb + k * j.sbk + n * j.sbn) % 2048;
                    e.c = (j.bc + m * j.scm + n * j.scn) % 2048;
                    e.last = (k == j.nk - 1) ? 1 : 0;
                    e.clr = (k == 0) ? 1 : 0;
                    exp_q.push_back(e);
                end
    endtask

    task automatic finish_job(input job_t j, input int inv0, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            start_reg = (j.toggle != 0) ? ~start_reg : 1'b0;
            cyc++;
        end while (!done && cyc < 3000);
        start_reg = 1'b0;
        check("job_done", done, 1);
        check("job_tiles_issued", tiles_issued, j.exp_tiles);
        check("job_invocations", inv_cnt - inv0, j.exp_tiles);
        check("job_pending_expected", exp_q.size(), 0);
        check("done_busy_low", busy, 0);
        check("done_last_k_low", core_last_k, 0);
        repeat (2) @(negedge clk);
        check("done_holds", done, 1);
        clear_done_reg = 1'b1;
        @(negedge clk);
        clear_done_reg = 1'b0;
        check("clear_done_low", done, 0);
        check("clear_busy_low", busy, 0);
    endtask

    job_t jobs[7];

    initial begin
        job_t j;
        int inv0, cyc;

        jobs[0] = '{1, 1, 1, 'h010, 'h020, 'h030, 5, 6, 7, 8, 9, 10, 5, 1, 0, 1};
        jobs[1] = '{2, 2, 2, 0, 0, 0, 16, 8, 16, 8, 16, 8, 3, 1, 0, 8};
        jobs[2] = '{1, 1, 2, 'h7F8, 0, 0, 0, 16, 4, 0, 0, 0, 2, 1, 0, 2};
        jobs[3] = '{1, 1, 0, 5, 6, 7, 1, 1, 1, 1, 1, 1, 3, 1, 0, 0};
        jobs[4] = '{1, 2, 1, 'h100, 'h200, 'h300, 1, 2, 3, 4, 5, 6, 4, 4, 1, 2};
        jobs[5] = '{3, 2, 3, 'h7F0, 'h7E0, 'h7C0, 200, 255, 17, 129, 33, 250, 2, 2, 0, 18};
        jobs[6] = '{0, 3, 3, 1, 2, 3, 4, 5, 6, 7, 8, 9, 3, 1, 0, 0};

        resetn = 1'b0;
        start_reg = 1'b0;
        clear_done_reg = 1'b0;
        start_job('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0});
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_core_start", core_start, 0);
        check("rst_pe_resetn", core_pe_resetn, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tiles", tiles_issued, 0);
        check("rst_addr_a", core_addr_a, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Single tile, cycle-exact start sequence.
        j = jobs[0];
        inv0 = inv_cnt;
        start_job(j);
        start_reg = 1'b1;
        @(posedge clk);
        #1;
        start_reg = 1'b0;
        check("t1_pe_resetn_low", core_pe_resetn, 0);
        check("t1_core_start_low", core_start, 0);
        check("t1_busy", busy, 1);
        check("t1_addr_a", core_addr_a, 'h010);
        check("t1_addr_b", core_addr_b, 'h020);
        check("t1_addr_c", core_addr_c, 'h030);
        check("t1_last_k", core_last_k, 1);
        @(posedge clk);
        #1;
        check("t2_core_start", core_start, 1);
        check("t2_pe_resetn_high", core_pe_resetn, 1);
        finish_job(j, inv0, cyc);

        for (int i = 0; i < 7; i++) begin
            j = jobs[i];
            inv0 = inv_cnt;
            start_job(j);
            @(negedge clk);
            start_reg = 1'b1;
            finish_job(j, inv0, cyc);
            if (j.exp_tiles == 0) check("zero_count_latency", cyc, 1);
        end

        // Reset in the middle of the second tile's WAIT.
        j = jobs[1];
        j.lat = 6;
        inv0 = inv_cnt;
        start_job(j);
        @(negedge clk);
        start_reg = 1'b1;
        @(negedge clk);
        start_reg = 1'b0;
        repeat (12) @(negedge clk);
        check("pre_reset_tiles", tiles_issued, 1);
        check("pre_reset_core_start", core_start, 1);
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_core_start", core_start, 0);
        check("midrst_busy", busy, 0);
        check("midrst_tiles", tiles_issued, 0);
        check("midrst_pe_resetn", core_pe_resetn, 1);
        check("midrst_addr_a", core_addr_a, 0);
        resetn = 1'b1;
        exp_q.delete();
        repeat (20) @(negedge clk);
        check("post_reset_idle_busy", busy, 0);
        check("post_reset_idle_start", core_start, 0);
        check("post_reset_done", done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
